lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_next.sv | 11 +
 rtl/lfsr_checker.sv | 143 ++++++++++++++
 tb/tb_lfsr_checker.sv | 135 +++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: width, Galois polynomial, checker state encoding
// and the next-state function used by both generator and checker.
package lfsr_pkg;

  localparam int          LFSR_W    = 8;
  localparam logic [7:0]  LFSR_POLY = 8'h1D;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_SEEDED   = 2'd1,
    ST_LOCKED   = 2'd2
  } chk_state_e;

  // Galois step for x^8+x^4+x^3+x^2+1.
  function automatic logic [LFSR_W-1:0] lfsr_next_f(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR next-state block wrapping the shared package function.
module lfsr_next
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt
);

  assign nxt = lfsr_next_f(cur);

endmodule

// File: rtl/lfsr_checker.sv
// LFSR sequence checker with lock/loss hysteresis and an error pulse.
// Define LFSR_CHECKER_ERRCNT_EN to build the saturating error counter.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [LFSR_W-1:0] data_in,
  input  logic              err_clr,
  output logic              lock,
  output logic              err,
  output logic [15:0]       err_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] pred_q, pred_d;
  logic [MW-1:0]     match_cnt_q, match_cnt_d;
  logic [LW-1:0]     miss_cnt_q, miss_cnt_d;
  logic              lock_q, lock_d;
  logic              err_q, err_d;

  logic              mismatch;
  logic              lose;
  logic [LFSR_W-1:0] next_src;
  logic [LFSR_W-1:0] next_val;

  assign mismatch = (data_in != pred_q);
  assign lose     = (state_q == ST_LOCKED) && data_valid && mismatch &&
                    (miss_cnt_q == LW'(LOSS_CNT - 1));

  // While locked the prediction free-runs; every other path steps from the received word.
  assign next_src = ((state_q == ST_LOCKED) && !lose) ? pred_q : data_in;

  lfsr_next u_next (
    .cur (next_src),
    .nxt (next_val)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    pred_d      = pred_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    if (data_valid) begin
      unique case (state_q)
        ST_UNSEEDED: begin
          if (data_in != '0) begin
            pred_d      = next_val;
            match_cnt_d = '0;
            state_d     = ST_SEEDED;
          end
        end
        ST_SEEDED: begin
          if (data_in == '0) begin
            state_d     = ST_UNSEEDED;
            match_cnt_d = '0;
          end else if (!mismatch) begin
            pred_d = next_val;
            if (match_cnt_q == MW'(LOCK_CNT - 1)) begin
              state_d     = ST_LOCKED;
              miss_cnt_d  = '0;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + MW'(1);
            end
          end else begin
            pred_d      = next_val;
            match_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          pred_d = next_val;
          if (!mismatch) begin
            miss_cnt_d = '0;
          end else begin
            err_d = 1'b1;
            if (lose) begin
              state_d     = (data_in == '0) ? ST_UNSEEDED : ST_SEEDED;
              match_cnt_d = '0;
              miss_cnt_d  = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + LW'(1);
            end
          end
        end
        default: state_d = ST_UNSEEDED;
      endcase
    end
    lock_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= ST_UNSEEDED;
      pred_q      <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      lock_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      lock_q      <= lock_d;
      err_q       <= err_d;
    end
  end

  assign lock = lock_q;
  assign err  = err_q;

`ifdef LFSR_CHECKER_ERRCNT_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_clr ? 16'h0000 : err_count_q;
    if (err_d && (err_count_d != 16'hFFFF)) err_count_d = err_count_d + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_count_q <= 16'h0000;
    else     err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = 16'h0000;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed-vector bench for lfsr_checker: the driver queues hand-computed
// expectations, a monitor pops and compares them one cycle after each edge.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_valid = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        err_clr = 1'b0;
  logic        lock;
  logic        err;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        lock;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data_in    (data_in),
    .err_clr    (err_clr),
    .lock       (lock),
    .err        (err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one edge's inputs and queue the outputs expected after that edge.
  task automatic step(input string nm, input logic v, input logic [7:0] d,
                      input logic c, input logic r,
                      input logic el, input logic ee, input logic [15:0] ec);
    exp_t e;
    @(negedge clk);
    rst = r; data_valid = v; data_in = d; err_clr = c;
    @(posedge clk);
    #1;
    e.name = nm;
    e.lock = el;
    e.err  = ee;
`ifdef LFSR_CHECKER_ERRCNT_EN
    e.cnt  = ec;
`else
    e.cnt  = 16'h0000;
`endif
    exp_q.push_back(e);
    rst = 1'b0; data_valid = 1'b0; err_clr = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".lock"},      {15'd0, lock}, {15'd0, e.lock});
        check({e.name, ".err"},       {15'd0, err},  {15'd0, e.err});
        check({e.name, ".err_count"}, err_count,     e.cnt);
      end
    end
  end

  initial begin : driver
    //    name        v  data  clr rst  lock err cnt
    step("reset0",    0, 8'h00, 0, 1,   0, 0, 0);
    step("reset1",    1, 8'hA5, 1, 1,   0, 0, 0);

    step("acq_a5",    1, 8'hA5, 0, 0,   0, 0, 0);
    step("acq_57",    1, 8'h57, 0, 0,   0, 0, 0);
    step("acq_ae",    1, 8'hAE, 0, 0,   0, 0, 0);
    step("acq_41",    1, 8'h41, 0, 0,   0, 0, 0);
    step("acq_82",    1, 8'h82, 0, 0,   1, 0, 0);

    step("bad_33",    1, 8'h33, 0, 0,   1, 1, 1);
    step("ok_32",     1, 8'h32, 0, 0,   1, 0, 1);
    step("ok_64",     1, 8'h64, 0, 0,   1, 0, 1);

    for (int i = 0; i < 5; i++)
      step("stall",   0, 8'hAA, 0, 0,   1, 0, 1);
    step("ok_c8",     1, 8'hC8, 0, 0,   1, 0, 1);

    step("clr_err",   1, 8'h00, 1, 0,   1, 1, 1);
    step("ok_07",     1, 8'h07, 0, 0,   1, 0, 1);
    step("clr_idle",  0, 8'h00, 1, 0,   1, 0, 0);

    step("loss1",     1, 8'h00, 0, 0,   1, 1, 1);
    step("loss2",     1, 8'h00, 0, 0,   1, 1, 2);
    step("loss3",     1, 8'h00, 0, 0,   0, 1, 3);
    step("seed_0e",   1, 8'h0E, 0, 0,   0, 0, 3);

    step("rst_mid",   1, 8'hA5, 0, 1,   0, 0, 0);
    step("rs_a5",     1, 8'hA5, 0, 0,   0, 0, 0);
    step("rs_57",     1, 8'h57, 0, 0,   0, 0, 0);
    step("rs_ff",     1, 8'hFF, 0, 0,   0, 0, 0);
    step("rs_e3",     1, 8'hE3, 0, 0,   0, 0, 0);
    step("rs_db",     1, 8'hDB, 0, 0,   0, 0, 0);
    step("rs_ab",     1, 8'hAB, 0, 0,   0, 0, 0);
    step("rs_4b",     1, 8'h4B, 0, 0,   1, 0, 0);
    step("rs_bad",    1, 8'h00, 0, 0,   1, 1, 1);
    step("rst_lock",  1, 8'h96, 1, 1,   0, 0, 0);

    step("z_a5",      1, 8'hA5, 0, 0,   0, 0, 0);
    step("z_00",      1, 8'h00, 0, 0,   0, 0, 0);
    step("z_57",      1, 8'h57, 0, 0,   0, 0, 0);
    step("z_ae",      1, 8'hAE, 0, 0,   0, 0, 0);
    step("z_41",      1, 8'h41, 0, 0,   0, 0, 0);
    step("z_82",      1, 8'h82, 0, 0,   0, 0, 0);
    step("z_19",      1, 8'h19, 0, 0,   1, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
